// File: rtl/interrupt_sequencer.sv
// -----------------------------------------------------------------------------
// interrupt_sequencer
//
// Drives the k6502 datapath through the 8-cycle entry sequence shared by
// reset, NMI, IRQ and BRK: two dummy reads, three stack pushes (PCH, PCL, P),
// a vector fetch (low then high byte), and the PC load plus first opcode
// fetch. While busy=1 this block owns the datapath control lines. The top
// level ORs its ctl_* outputs with the decoder's. Pending interrupts are
// prioritised at every instruction boundary (insn_end while in RUN).
//
// Ports
//   ph0, reset_n           clock (posedge) and asynchronous active-low reset
//   nmi_n                  NMI request, falling-edge sensitive, synchronised
//   irq_n                  IRQ request, level sensitive, not latched
//   i_flag                 P.I interrupt-disable flag
//   brk, insn_end          decoder: BRK opcode / last cycle of instruction
//   busy                   sequencer owns the datapath
//   rw                     external bus direction, 1 = read
//   sync                   opcode fetch cycle (last sequence cycle)
//   s_dec                  decrement S after a push
//   p_db, b_flag           drive P onto DB, with B bit = b_flag
//   set_i                  set P.I
//   ctl_*                  datapath transfer / pull-down / increment controls
// -----------------------------------------------------------------------------
module interrupt_sequencer #(
  parameter bit         NMI_HIJACK = 1'b1,
  parameter logic [7:0] STACK_PAGE = 8'h01
) (
  input  logic ph0,
  input  logic reset_n,
  input  logic nmi_n,
  input  logic irq_n,
  input  logic i_flag,
  input  logic brk,
  input  logic insn_end,
  output logic busy,
  output logic rw,
  output logic sync,
  output logic s_dec,
  output logic p_db,
  output logic b_flag,
  output logic set_i,
  output logic ctl_pch_adh,
  output logic ctl_pcl_adl,
  output logic ctl_adh_abh,
  output logic ctl_adl_abl,
  output logic ctl_s_adl,
  output logic ctl_pch_db,
  output logic ctl_pcl_db,
  output logic ctl_z_adh7_1,
  output logic ctl_z_adl0,
  output logic ctl_z_adl1,
  output logic ctl_z_adl2,
  output logic ctl_dl_db,
  output logic ctl_db_add,
  output logic ctl_z_add,
  output logic ctl_add_adl,
  output logic ctl_adl_pcl,
  output logic ctl_dl_adh,
  output logic ctl_adh_pch,
  output logic ctl_i_pc
);

  typedef enum logic [3:0] {
    S_RUN, S_C0, S_C1, S_C2, S_C3, S_C4, S_C5, S_C6, S_C7
  } state_t;

  typedef enum logic [1:0] {K_RST, K_NMI, K_BRK, K_IRQ} kind_t;

  // The ADH pull-downs can only form page 01; any other page leaves ADH
  // undriven by the stack path rather than producing a wrong address.
  localparam logic PAGE_OK = (STACK_PAGE == 8'h01);

  state_t state, state_nx;
  kind_t  kind, kind_nx;
  logic   rst_pend, nmi_pend, nmi_n_q;
  logic   nmi_edge, take;

  assign nmi_edge = nmi_n_q & ~nmi_n;
  assign take     = insn_end & (rst_pend | nmi_pend | brk | (~irq_n & ~i_flag));

  always_ff @(posedge ph0 or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_C0;
      kind     <= K_RST;
      rst_pend <= 1'b1;
      nmi_pend <= 1'b0;
      nmi_n_q  <= 1'b1;
    end else begin
      state   <= state_nx;
      kind    <= kind_nx;
      nmi_n_q <= nmi_n;
      if (state == S_C5)
        rst_pend <= 1'b0;
      // A fresh edge in the same cycle as the clear must not be lost.
      if (nmi_edge)
        nmi_pend <= 1'b1;
      else if (state == S_C5 && kind == K_NMI)
        nmi_pend <= 1'b0;
    end
  end

  always_comb begin
    state_nx = state;
    kind_nx  = kind;
    unique case (state)
      S_RUN: begin
        if (take) begin
          state_nx = S_C0;
          if (rst_pend)      kind_nx = K_RST;
          else if (nmi_pend) kind_nx = K_NMI;
          else if (brk)      kind_nx = K_BRK;
          else               kind_nx = K_IRQ;
        end
      end
      S_C0: state_nx = S_C1;
      S_C1: state_nx = S_C2;
      S_C2: state_nx = S_C3;
      S_C3: state_nx = S_C4;
      S_C4: begin
        state_nx = S_C5;
        // Last chance to redirect to the NMI vector before it is fetched.
        if (NMI_HIJACK && nmi_pend && (kind == K_IRQ || kind == K_BRK))
          kind_nx = K_NMI;
      end
      S_C5: state_nx = S_C6;
      S_C6: state_nx = S_C7;
      S_C7: state_nx = S_RUN;
      default: state_nx = S_RUN;
    endcase
  end

  always_comb begin
    busy         = (state != S_RUN);
    rw           = 1'b1;
    sync         = 1'b0;
    s_dec        = 1'b0;
    p_db         = 1'b0;
    b_flag       = 1'b0;
    set_i        = 1'b0;
    ctl_pch_adh  = 1'b0;
    ctl_pcl_adl  = 1'b0;
    ctl_adh_abh  = (state != S_RUN);
    ctl_adl_abl  = (state != S_RUN);
    ctl_s_adl    = 1'b0;
    ctl_pch_db   = 1'b0;
    ctl_pcl_db   = 1'b0;
    ctl_z_adh7_1 = 1'b0;
    ctl_z_adl0   = 1'b0;
    ctl_z_adl1   = 1'b0;
    ctl_z_adl2   = 1'b0;
    ctl_dl_db    = 1'b0;
    ctl_db_add   = 1'b0;
    ctl_z_add    = 1'b0;
    ctl_add_adl  = 1'b0;
    ctl_adl_pcl  = 1'b0;
    ctl_dl_adh   = 1'b0;
    ctl_adh_pch  = 1'b0;
    ctl_i_pc     = 1'b0;
    case (state)
      S_C0, S_C1: begin
        ctl_pch_adh = 1'b1;
        ctl_pcl_adl = 1'b1;
        // BRK skips its signature byte; hardware interrupts re-run the opcode.
        ctl_i_pc    = (state == S_C0) && (kind == K_BRK);
      end
      S_C2, S_C3, S_C4: begin
        ctl_s_adl    = 1'b1;
        ctl_z_adh7_1 = PAGE_OK;
        s_dec        = 1'b1;
        // Reset performs the pushes as reads so memory is left untouched.
        rw           = (kind == K_RST);
        ctl_pch_db   = (state == S_C2);
        ctl_pcl_db   = (state == S_C3);
        p_db         = (state == S_C4);
        b_flag       = (state == S_C4) && (kind == K_BRK);
      end
      S_C5: begin
        // ADH/ADL precharge to FF; pull-downs select FFFC / FFFA / FFFE.
        ctl_z_adl0 = 1'b1;
        ctl_z_adl1 = (kind == K_RST);
        ctl_z_adl2 = (kind == K_NMI);
        set_i      = 1'b1;
      end
      S_C6: begin
        ctl_z_adl1 = (kind == K_RST);
        ctl_z_adl2 = (kind == K_NMI);
        ctl_dl_db  = 1'b1;
        ctl_db_add = 1'b1;
        ctl_z_add  = 1'b1;
      end
      S_C7: begin
        ctl_add_adl = 1'b1;
        ctl_adl_pcl = 1'b1;
        ctl_dl_adh  = 1'b1;
        ctl_adh_pch = 1'b1;
        ctl_i_pc    = 1'b1;
        sync        = 1'b1;
      end
      default: ;
    endcase
    // Outputs are forced to their quiet reset values while reset is held.
    if (!reset_n) begin
      busy         = 1'b1;
      rw           = 1'b1;
      sync         = 1'b0;
      s_dec        = 1'b0;
      p_db         = 1'b0;
      b_flag       = 1'b0;
      set_i        = 1'b0;
      ctl_pch_adh  = 1'b0;
      ctl_pcl_adl  = 1'b0;
      ctl_adh_abh  = 1'b0;
      ctl_adl_abl  = 1'b0;
      ctl_s_adl    = 1'b0;
      ctl_pch_db   = 1'b0;
      ctl_pcl_db   = 1'b0;
      ctl_z_adh7_1 = 1'b0;
      ctl_z_adl0   = 1'b0;
      ctl_z_adl1   = 1'b0;
      ctl_z_adl2   = 1'b0;
      ctl_dl_db    = 1'b0;
      ctl_db_add   = 1'b0;
      ctl_z_add    = 1'b0;
      ctl_add_adl  = 1'b0;
      ctl_adl_pcl  = 1'b0;
      ctl_dl_adh   = 1'b0;
      ctl_adh_pch  = 1'b0;
      ctl_i_pc     = 1'b0;
    end
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// -----------------------------------------------------------------------------
// tb_interrupt_sequencer
//
// Table-driven bench. Each record holds the inputs for one clock cycle and
// the hand-computed bus activity expected in that cycle. A small abstract
// datapath (PC, S, P, DL, ADD and a few memory bytes) turns the sequencer's
// control lines into an address bus and write data, which are compared
// against the table.
// -----------------------------------------------------------------------------
module tb_interrupt_sequencer;

  logic ph0 = 1'b0;
  logic reset_n = 1'b0;
  logic nmi_n = 1'b1, irq_n = 1'b1, i_flag = 1'b0, brk = 1'b0, insn_end = 1'b0;
  logic busy, rw, sync, s_dec, p_db, b_flag, set_i;
  logic ctl_pch_adh, ctl_pcl_adl, ctl_adh_abh, ctl_adl_abl, ctl_s_adl;
  logic ctl_pch_db, ctl_pcl_db, ctl_z_adh7_1, ctl_z_adl0, ctl_z_adl1;
  logic ctl_z_adl2, ctl_dl_db, ctl_db_add, ctl_z_add, ctl_add_adl;
  logic ctl_adl_pcl, ctl_dl_adh, ctl_adh_pch, ctl_i_pc;

  always #5 ph0 = ~ph0;

  interrupt_sequencer dut (
    .ph0(ph0), .reset_n(reset_n), .nmi_n(nmi_n), .irq_n(irq_n),
    .i_flag(i_flag), .brk(brk), .insn_end(insn_end),
    .busy(busy), .rw(rw), .sync(sync), .s_dec(s_dec), .p_db(p_db),
    .b_flag(b_flag), .set_i(set_i),
    .ctl_pch_adh(ctl_pch_adh), .ctl_pcl_adl(ctl_pcl_adl),
    .ctl_adh_abh(ctl_adh_abh), .ctl_adl_abl(ctl_adl_abl),
    .ctl_s_adl(ctl_s_adl), .ctl_pch_db(ctl_pch_db), .ctl_pcl_db(ctl_pcl_db),
    .ctl_z_adh7_1(ctl_z_adh7_1), .ctl_z_adl0(ctl_z_adl0),
    .ctl_z_adl1(ctl_z_adl1), .ctl_z_adl2(ctl_z_adl2),
    .ctl_dl_db(ctl_dl_db), .ctl_db_add(ctl_db_add), .ctl_z_add(ctl_z_add),
    .ctl_add_adl(ctl_add_adl), .ctl_adl_pcl(ctl_adl_pcl),
    .ctl_dl_adh(ctl_dl_adh), .ctl_adh_pch(ctl_adh_pch), .ctl_i_pc(ctl_i_pc)
  );

  logic [24:0] quiet_vec;
  assign quiet_vec = {sync, s_dec, p_db, b_flag, set_i, ctl_pch_adh,
                      ctl_pcl_adl, ctl_adh_abh, ctl_adl_abl, ctl_s_adl,
                      ctl_pch_db, ctl_pcl_db, ctl_z_adh7_1, ctl_z_adl0,
                      ctl_z_adl1, ctl_z_adl2, ctl_dl_db, ctl_db_add, ctl_z_add,
                      ctl_add_adl, ctl_adl_pcl, ctl_dl_adh, ctl_adh_pch,
                      ctl_i_pc, 1'b0};

  typedef struct {
    logic        rst_n, nmi_n, irq_n, i_flag, brk, insn_end;
    logic        busy, rw, sync, set_i;
    logic        chk_bus;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } vec_t;

  vec_t tv[$];
  int   n_chk = 0;
  int   n_err = 0;

  logic [15:0] m_pc;
  logic [7:0]  m_s, m_p, m_dl, m_add;

  function automatic logic [7:0] mem(input logic [15:0] a);
    case (a)
      16'hFFFA: return 8'h00;
      16'hFFFB: return 8'h90;
      16'hFFFC: return 8'h34;
      16'hFFFD: return 8'h12;
      16'hFFFE: return 8'h00;
      16'hFFFF: return 8'h80;
      default:  return 8'hEA;
    endcase
  endfunction

  task automatic add(input logic r, input logic nm, input logic iq,
                     input logic fi, input logic bk, input logic ie,
                     input logic eb, input logic erw, input logic es,
                     input logic ei, input logic ck, input logic [15:0] ea,
                     input logic [7:0] ed);
    vec_t v;
    v.rst_n = r; v.nmi_n = nm; v.irq_n = iq; v.i_flag = fi; v.brk = bk;
    v.insn_end = ie; v.busy = eb; v.rw = erw; v.sync = es; v.set_i = ei;
    v.chk_bus = ck; v.addr = ea; v.wdata = ed;
    tv.push_back(v);
  endtask

  task automatic check_cycle(input int i);
    logic [7:0]  adh, adl, dbus;
    logic [15:0] a;
    adh = 8'hFF;
    adl = 8'hFF;
    if (ctl_pch_adh)  adh = m_pc[15:8];
    if (ctl_dl_adh)   adh = m_dl;
    if (ctl_z_adh7_1) adh = adh & 8'h01;
    if (ctl_pcl_adl)  adl = m_pc[7:0];
    if (ctl_s_adl)    adl = m_s;
    if (ctl_add_adl)  adl = m_add;
    if (ctl_z_adl0)   adl = adl & 8'hFE;
    if (ctl_z_adl1)   adl = adl & 8'hFD;
    if (ctl_z_adl2)   adl = adl & 8'hFB;
    a = {adh, adl};
    dbus = 8'h00;
    if (ctl_pch_db) dbus = m_pc[15:8];
    if (ctl_pcl_db) dbus = m_pc[7:0];
    if (p_db)       dbus = {m_p[7:5], b_flag, m_p[3:0]};

    n_chk++;
    if ({busy, rw, sync, set_i} !== {tv[i].busy, tv[i].rw, tv[i].sync, tv[i].set_i}) begin
      n_err++;
      $display("FAIL vec%0d status busy/rw/sync/set_i: got %b required %b", i,
               {busy, rw, sync, set_i}, {tv[i].busy, tv[i].rw, tv[i].sync, tv[i].set_i});
    end
    if (!tv[i].busy || !tv[i].rst_n) begin
      n_chk++;
      if (quiet_vec !== '0) begin
        n_err++;
        $display("FAIL vec%0d quiet_ctl: got %b required all zero", i, quiet_vec);
      end
    end
    if (tv[i].chk_bus) begin
      n_chk++;
      if (a !== tv[i].addr) begin
        n_err++;
        $display("FAIL vec%0d addr: got %h required %h", i, a, tv[i].addr);
      end
      if (!tv[i].rw) begin
        n_chk++;
        if (dbus !== tv[i].wdata) begin
          n_err++;
          $display("FAIL vec%0d wdata: got %h required %h", i, dbus, tv[i].wdata);
        end
      end
    end

    if (reset_n) begin
      if (ctl_dl_db && ctl_db_add && ctl_z_add) m_add = m_dl;
      if (rw) m_dl = mem(a);
      if (s_dec) m_s = m_s - 8'd1;
      if (set_i) m_p[2] = 1'b1;
      if (ctl_adl_pcl && ctl_adh_pch) m_pc = a + {15'd0, ctl_i_pc};
      else if (ctl_i_pc)              m_pc = m_pc + 16'd1;
    end
  endtask

  task automatic apply_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      @(posedge ph0);
      #1;
      reset_n  = tv[i].rst_n;
      nmi_n    = tv[i].nmi_n;
      irq_n    = tv[i].irq_n;
      i_flag   = tv[i].i_flag;
      brk      = tv[i].brk;
      insn_end = tv[i].insn_end;
      @(negedge ph0);
      check_cycle(i);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // rst nmi irq i brk end | busy rw sync seti | chk addr wdata
    // Power-up reset and the RST entry sequence (records 0..10)
    add(0,1,1,0,0,0, 1,1,0,0, 0,16'h0000,8'h00);
    add(0,1,1,0,0,0, 1,1,0,0, 0,16'h0000,8'h00);
    add(1,1,1,0,0,0, 1,1,0,0, 1,16'h0000,8'h00);
    add(1,1,1,0,0,0, 1,1,0,0, 1,16'h0000,8'h00);
    add(1,1,1,0,0,0, 1,1,0,0, 1,16'h0100,8'h00);
    add(1,1,1,0,0,0, 1,1,0,0, 1,16'h01FF,8'h00);
    add(1,1,1,0,0,0, 1,1,0,0, 1,16'h01FE,8'h00);
    add(1,1,1,0,0,0, 1,1,0,1, 1,16'hFFFC,8'h00);
    add(1,1,1,0,0,0, 1,1,0,0, 1,16'hFFFD,8'h00);
    add(1,1,1,0,0,0, 1,1,1,0, 1,16'h1234,8'h00);
    add(1,1,1,0,0,0, 0,1,0,0, 0,16'h0000,8'h00);
    // IRQ from PC=0300, S=FD (records 11..19)
    add(1,1,0,0,0,1, 0,1,0,0, 0,16'h0000,8'h00);
    add(1,1,1,0,0,0, 1,1,0,0, 1,16'h0300,8'h00);
    add(1,1,1,0,0,0, 1,1,0,0, 1,16'h0300,8'h00);
    add(1,1,1,0,0,0, 1,0,0,0, 1,16'h01FD,8'h03);
    add(1,1,1,0,0,1, 1,0,0,0, 1,16'h01FC,8'h00);
    add(1,1,1,0,0,0, 1,0,0,0, 1,16'h01FB,8'h24);
    add(1,1,1,0,0,0, 1,1,0,1, 1,16'hFFFE,8'h00);
    add(1,1,1,0,0,0, 1,1,0,0, 1,16'hFFFF,8'h00);
    add(1,1,1,0,0,0, 1,1,1,0, 1,16'h8000,8'h00);
    // IRQ masked by i_flag (records 20..21)
    add(1,1,0,1,0,1, 0,1,0,0, 0,16'h0000,8'h00);
    add(1,1,1,0,0,0, 0,1,0,0, 0,16'h0000,8'h00);
    // IRQ hijacked by an NMI edge in C3 (records 22..33)
    add(1,1,0,0,0,1, 0,1,0,0, 0,16'h0000,8'h00);
    add(1,1,1,0,0,0, 1,1,0,0, 1,16'h8001,8'h00);
    add(1,1,1,0,0,0, 1,1,0,0, 1,16'h8001,8'h00);
    add(1,1,1,0,0,0, 1,0,0,0, 1,16'h01FA,8'h80);
    add(1,0,1,0,0,0, 1,0,0,0, 1,16'h01F9,8'h01);
    add(1,0,1,0,0,0, 1,0,0,0, 1,16'h01F8,8'h24);
    add(1,0,1,0,0,0, 1,1,0,1, 1,16'hFFFA,8'h00);
    add(1,0,1,0,0,0, 1,1,0,0, 1,16'hFFFB,8'h00);
    add(1,0,1,0,0,0, 1,1,1,0, 1,16'h9000,8'h00);
    add(1,0,1,0,0,1, 0,1,0,0, 0,16'h0000,8'h00);
    add(1,1,1,0,0,0, 0,1,0,0, 0,16'h0000,8'h00);
    add(1,1,1,0,0,1, 0,1,0,0, 0,16'h0000,8'h00);
    // BRK (records 34..42)
    add(1,1,1,0,1,1, 0,1,0,0, 0,16'h0000,8'h00);
    add(1,1,1,0,0,0, 1,1,0,0, 1,16'h9001,8'h00);
    add(1,1,1,0,0,0, 1,1,0,0, 1,16'h9002,8'h00);
    add(1,1,1,0,0,0, 1,0,0,0, 1,16'h01F7,8'h90);
    add(1,1,1,0,0,0, 1,0,0,0, 1,16'h01F6,8'h02);
    add(1,1,1,0,0,0, 1,0,0,0, 1,16'h01F5,8'h34);
    add(1,1,1,0,0,0, 1,1,0,1, 1,16'hFFFE,8'h00);
    add(1,1,1,0,0,0, 1,1,0,0, 1,16'hFFFF,8'h00);
    add(1,1,1,0,0,0, 1,1,1,0, 1,16'h8000,8'h00);
    // NMI latched in RUN, beats a simultaneous IRQ (records 43..53)
    add(1,0,0,0,0,0, 0,1,0,0, 0,16'h0000,8'h00);
    add(1,0,0,0,0,1, 0,1,0,0, 0,16'h0000,8'h00);
    add(1,0,1,0,0,0, 1,1,0,0, 1,16'h8001,8'h00);
    add(1,0,1,0,0,0, 1,1,0,0, 1,16'h8001,8'h00);
    add(1,0,1,0,0,0, 1,0,0,0, 1,16'h01F4,8'h80);
    add(1,0,1,0,0,0, 1,0,0,0, 1,16'h01F3,8'h01);
    add(1,0,1,0,0,0, 1,0,0,0, 1,16'h01F2,8'h24);
    add(1,0,1,0,0,0, 1,1,0,1, 1,16'hFFFA,8'h00);
    add(1,0,1,0,0,0, 1,1,0,0, 1,16'hFFFB,8'h00);
    add(1,0,1,0,0,0, 1,1,1,0, 1,16'h9000,8'h00);
    add(1,1,1,0,0,0, 0,1,0,0, 0,16'h0000,8'h00);
    // Reset asserted in C3 of an IRQ entry, then RST restart (records 54..68)
    add(1,1,0,0,0,1, 0,1,0,0, 0,16'h0000,8'h00);
    add(1,1,1,0,0,0, 1,1,0,0, 1,16'h9001,8'h00);
    add(1,1,1,0,0,0, 1,1,0,0, 1,16'h9001,8'h00);
    add(1,1,1,0,0,0, 1,0,0,0, 1,16'h01F1,8'h90);
    add(0,1,1,0,0,1, 1,1,0,0, 0,16'h0000,8'h00);
    add(1,1,1,0,0,0, 1,1,0,0, 1,16'h9001,8'h00);
    add(1,1,1,0,0,0, 1,1,0,0, 1,16'h9001,8'h00);
    add(1,1,1,0,0,0, 1,1,0,0, 1,16'h01F0,8'h00);
    add(1,1,1,0,0,0, 1,1,0,0, 1,16'h01EF,8'h00);
    add(1,1,1,0,0,0, 1,1,0,0, 1,16'h01EE,8'h00);
    add(1,1,1,0,0,0, 1,1,0,1, 1,16'hFFFC,8'h00);
    add(1,1,1,0,0,0, 1,1,0,0, 1,16'hFFFD,8'h00);
    add(1,1,1,0,0,0, 1,1,1,0, 1,16'h1234,8'h00);
    add(1,1,1,0,0,1, 0,1,0,0, 0,16'h0000,8'h00);
    add(1,1,1,0,0,0, 0,1,0,0, 0,16'h0000,8'h00);

    m_pc  = 16'h0000;
    m_s   = 8'h00;
    m_p   = 8'h20;
    m_dl  = 8'h00;
    m_add = 8'h00;
    apply_range(0, 10);

    // Place the CPU at PC=0300, S=FD before the first interrupt.
    m_pc = 16'h0300;
    m_s  = 8'hFD;
    apply_range(11, tv.size() - 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
